fetch_sequencer: RTL and testbench

// - Sequences the combinational instruction memory: owns the PC register and drives the word-read address.
// - Chooses next PC: sequential (+4), branch target or jump target. Applies hazard stalls.
// - Writes the IF/ID pipeline register. Detects halt and fault conditions.
// - Sits between the instruction memory and the decode stage of the pipelined MIPS datapath.

---
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch stage sequencer: owns the PC, drives instruction-memory address, fills IF/ID.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  BOOT  | one cycle after reset, PC held, IF/ID bubble
//  RUN   | normal fetch: redirect > stall > halt detect > sequential
//  HALT  | HALT_WORD seen, PC frozen until a redirect arrives
//  FAULT | bad redirect target or PC ran off the end; terminal to reset
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls,
    output logic [31:0] perf_flushes,
`endif
    output logic        fault
);

    localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_tgt;
    logic        tgt_bad;
    logic        redirect_ok;
    logic        stall_run;
    logic        halt_seen;
    logic        seq_end;
    logic        fetch_ok;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    always_comb begin
        redirect     = jump | branch_taken;
        redirect_tgt = jump ? jump_target : branch_target;
        tgt_bad      = (redirect_tgt[1:0] != 2'b00) || (redirect_tgt >= PC_LIMIT);
        redirect_ok  = redirect && !tgt_bad && (state == RUN || state == HALT);
        stall_run    = (state == RUN) && !redirect && stall;
        halt_seen    = (state == RUN) && !redirect && !stall && (imem_instr == HALT_WORD);
        // The last legal word is never fetched sequentially because PC+4 would leave memory.
        seq_end      = (state == RUN) && !redirect && !stall && !halt_seen && (pc_plus4 == PC_LIMIT);
        fetch_ok     = (state == RUN) && !redirect && !stall && !halt_seen && !seq_end;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            if_id_instr    <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
            fault          <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN, HALT: begin
                    if (redirect) begin
                        if_id_instr <= 32'd0;
                        if_id_valid <= 1'b0;
                        if (tgt_bad) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end else begin
                            pc     <= redirect_tgt;
                            halted <= 1'b0;
                            state  <= RUN;
                        end
                    end else if (state == RUN && !stall) begin
                        if (halt_seen) begin
                            if_id_instr <= 32'd0;
                            if_id_valid <= 1'b0;
                            halted      <= 1'b1;
                            state       <= HALT;
                        end else if (seq_end) begin
                            if_id_instr <= 32'd0;
                            if_id_valid <= 1'b0;
                            fault       <= 1'b1;
                            state       <= FAULT;
                        end else begin
                            if_id_instr    <= imem_instr;
                            if_id_pc_plus4 <= pc_plus4;
                            if_id_valid    <= 1'b1;
                            pc             <= pc_plus4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            perf_fetched <= 32'd0;
            perf_stalls  <= 32'd0;
            perf_flushes <= 32'd0;
        end else begin
            if (fetch_ok)    perf_fetched <= sat_inc(perf_fetched);
            if (stall_run)   perf_stalls  <= sat_inc(perf_stalls);
            if (redirect_ok) perf_flushes <= sat_inc(perf_flushes);
        end
    end
`else
    logic unused_strobes;
    assign unused_strobes = stall_run ^ redirect_ok ^ fetch_ok;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table driven through an expected-value queue,
// plus short hand-built sequences for reset-from-fault and memory-boundary faults.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
    logic        fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
    logic [31:0] perf_flushes;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:1023];

    always #5 Clk = ~Clk;

    always_comb imem_instr = (imem_addr < 32'd4096) ? mem[imem_addr[11:2]] : 32'd0;

    fetch_sequencer dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls),
        .perf_flushes   (perf_flushes),
`endif
        .fault          (fault)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] br_tgt;
        logic        jmp;
        logic [31:0] jmp_tgt;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
        logic        valid;
        logic        halted;
        logic        fault;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
        logic        valid;
        logic        halted;
        logic        fault;
    } exp_t;

    exp_t sb[$];

    function automatic vec_t mk(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                                input logic jp, input logic [31:0] jt, input logic [31:0] addr,
                                input logic [31:0] instr, input logic [31:0] pc4, input logic cpc4,
                                input logic valid, input logic hlt, input logic flt);
        vec_t v;
        v.rst = rst; v.stall = st; v.br = br; v.br_tgt = bt; v.jmp = jp; v.jmp_tgt = jt;
        v.addr = addr; v.instr = instr; v.pc4 = pc4; v.chk_pc4 = cpc4;
        v.valid = valid; v.halted = hlt; v.fault = flt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        Reset         = v.rst;
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.br_tgt;
        jump          = v.jmp;
        jump_target   = v.jmp_tgt;
        e.addr = v.addr; e.instr = v.instr; e.pc4 = v.pc4; e.chk_pc4 = v.chk_pc4;
        e.valid = v.valid; e.halted = v.halted; e.fault = v.fault;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk({tag, " imem_addr"}, imem_addr, e.addr);
        chk({tag, " if_id_instr"}, if_id_instr, e.instr);
        if (e.chk_pc4) chk({tag, " if_id_pc_plus4"}, if_id_pc_plus4, e.pc4);
        chk({tag, " if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
        chk({tag, " halted"}, {31'd0, halted}, {31'd0, e.halted});
        chk({tag, " fault"}, {31'd0, fault}, {31'd0, e.fault});
    endtask

    vec_t vecs[19];
    vec_t rst_v;
    vec_t idle_boot;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[4] = 32'hFFFF_FFFF;
        Reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        jump = 1'b0; jump_target = 32'd0;

        rst_v     = mk(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        idle_boot = mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);

        //          rst st br bt         jp jt          addr        instr          pc4        c  v  h  f
        vecs[0]  = mk(1, 0, 0, 0,        0, 0,          32'h0,  32'h0,         32'h0,  1, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 32'h40,   1, 32'h80,     32'h0,  32'h0,         32'h0,  1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0,        0, 0,          32'h0,  32'h0,         32'h0,  1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0,        0, 0,          32'h4,  32'h2008_0005, 32'h4,  1, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,        0, 0,          32'h8,  32'h2009_0003, 32'h8,  1, 1, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0,        0, 0,          32'h8,  32'h2009_0003, 32'h8,  1, 1, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0,        0, 0,          32'h8,  32'h2009_0003, 32'h8,  1, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0,        0, 0,          32'hC,  32'hA000_0002, 32'hC,  1, 1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0,        0, 0,          32'h10, 32'hA000_0003, 32'h10, 1, 1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0,        0, 0,          32'h10, 32'h0,         32'h0,  0, 0, 1, 0);
        vecs[10] = mk(0, 1, 0, 0,        0, 0,          32'h10, 32'h0,         32'h0,  0, 0, 1, 0);
        vecs[11] = mk(0, 0, 1, 32'h0,    0, 0,          32'h0,  32'h0,         32'h0,  0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0,        0, 0,          32'h4,  32'h2008_0005, 32'h4,  1, 1, 0, 0);
        vecs[13] = mk(0, 1, 1, 32'h40,   0, 0,          32'h40, 32'h0,         32'h0,  0, 0, 0, 0);
        vecs[14] = mk(0, 0, 1, 32'h40,   1, 32'h80,     32'h80, 32'h0,         32'h0,  0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0,        0, 0,          32'h84, 32'hA000_0020, 32'h84, 1, 1, 0, 0);
        vecs[16] = mk(0, 0, 1, 32'h42,   0, 0,          32'h84, 32'h0,         32'h0,  0, 0, 0, 1);
        vecs[17] = mk(0, 0, 0, 0,        1, 32'h100,    32'h84, 32'h0,         32'h0,  0, 0, 0, 1);
        vecs[18] = mk(0, 1, 1, 32'h8,    0, 0,          32'h84, 32'h0,         32'h0,  0, 0, 0, 1);

        #1;
        for (int i = 0; i < 19; i++) apply(vecs[i], $sformatf("vec%0d", i));

`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'd6);
        chk("perf_stalls", perf_stalls, 32'd2);
        chk("perf_flushes", perf_flushes, 32'd3);
`endif

        // Reset out of FAULT, then an out-of-range jump from RUN.
        apply(rst_v, "fault_rst");
        apply(idle_boot, "oor_boot");
        apply(mk(0, 0, 0, 0, 1, 32'h1000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1), "oor_jump");
        apply(mk(0, 0, 0, 0, 1, 32'h8, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1), "oor_hold");

        // Last legal word: sequential PC+4 would reach the end of memory.
        apply(rst_v, "end_rst");
        apply(idle_boot, "end_boot");
        apply(mk(0, 0, 0, 0, 1, 32'hFFC, 32'hFFC, 32'h0, 32'h0, 0, 0, 0, 0), "end_jump");
        apply(mk(0, 0, 0, 0, 0, 0, 32'hFFC, 32'h0, 32'h0, 0, 0, 0, 1), "end_seq");
        apply(mk(0, 0, 0, 0, 0, 0, 32'hFFC, 32'h0, 32'h0, 0, 0, 0, 1), "end_hold");

        // Reset asserted during a stall and during HALT.
        apply(rst_v, "stl_rst");
        apply(idle_boot, "stl_boot");
        apply(mk(0, 0, 0, 0, 0, 0, 32'h4, 32'h2008_0005, 32'h4, 1, 1, 0, 0), "stl_fetch");
        apply(mk(0, 1, 0, 0, 0, 0, 32'h4, 32'h2008_0005, 32'h4, 1, 1, 0, 0), "stl_hold");
        apply(mk(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0), "stl_reset");
        apply(idle_boot, "hlt_boot");
        apply(mk(0, 0, 1, 32'h10, 0, 0, 32'h10, 32'h0, 32'h0, 0, 0, 0, 0), "hlt_br");
        apply(mk(0, 0, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0, 0, 0, 1, 0), "hlt_enter");
        apply(mk(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0), "hlt_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
